// File: rtl/spi_master_core_if.sv
// Bus-side strobes and data exchanged between the Wishbone front end and the SPI shift engine.
interface spi_master_core_if;
    localparam int unsigned DOUT_W = 11;
    localparam int unsigned DIN_W  = 9;

    logic [DOUT_W-1:0] dout;
    logic              cmd;
    logic              wr;
    logic              rd;
    logic [DIN_W-1:0]  din;
    logic              ack;

    modport master (output dout, cmd, wr, rd, input din, ack);
    modport slave  (input dout, cmd, wr, rd, output din, ack);
endinterface

// File: rtl/spi_master_core.sv
// SPI byte shift engine with programmable SCLK divider, CPOL/CPHA and chip-select hold.
// Optional SPI_LSB_FIRST_EN: cmd dout[10] selects LSB-first shifting.
module spi_master_core #(
    parameter int unsigned      DIV_W       = 8,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(4)
) (
    input  logic             clk,
    input  logic             rst,
    spi_master_core_if.slave bus,
    output logic             spi_sclk,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             spi_cs_n
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BIT_W  = 4;
    localparam int unsigned EDGE_W = 5;
    localparam logic [BIT_W-1:0]  NBITS     = BIT_W'(8);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(15);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t              state, state_nxt;
    logic [DIV_W-1:0]    div, div_nxt, cnt, cnt_nxt;
    logic                cpol, cpol_nxt, cpha, cpha_nxt, lsb;
    logic [BYTE_W-1:0]   tx, tx_nxt, rx_sh, rx_sh_nxt, rx_byte, rx_byte_nxt;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic [EDGE_W-1:0]   edge_cnt, edge_cnt_nxt;
    logic                keep, keep_nxt, rx_valid, rx_valid_nxt;
    logic                rd_pend, ack, ack_nxt;
    logic                sclk_nxt, mosi_nxt, cs_n_nxt;
    logic                cfg_load, half_done, sample;

    assign bus.ack = ack;
    assign bus.din = {rx_valid, rx_byte};

`ifdef SPI_LSB_FIRST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           lsb <= 1'b0;
        else if (cfg_load) lsb <= bus.dout[10];
    end
`else
    logic unused_lsb_sel;
    assign lsb            = 1'b0;
    assign unused_lsb_sel = bus.dout[10];
`endif

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        div_nxt      = div;
        cnt_nxt      = cnt;
        cpol_nxt     = cpol;
        cpha_nxt     = cpha;
        tx_nxt       = tx;
        rx_sh_nxt    = rx_sh;
        rx_byte_nxt  = rx_byte;
        bit_cnt_nxt  = bit_cnt;
        edge_cnt_nxt = edge_cnt;
        keep_nxt     = keep;
        rx_valid_nxt = rx_valid;
        sclk_nxt     = spi_sclk;
        mosi_nxt     = spi_mosi;
        cs_n_nxt     = spi_cs_n;
        ack_nxt      = bus.rd;
        cfg_load     = 1'b0;
        half_done    = (cnt == div);
        // leading edges are the odd ones (edge_cnt even before the edge)
        sample       = (~edge_cnt[0]) ^ cpha;

        // Read clear lands one cycle after its ack; a completing byte overrides it below
        if (rd_pend) rx_valid_nxt = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.cmd) begin
                    cfg_load = 1'b1;
                    div_nxt  = bus.dout[DIV_W-1:0];
                    cpol_nxt = bus.dout[8];
                    cpha_nxt = bus.dout[9];
                    sclk_nxt = bus.dout[8];
                    cs_n_nxt = 1'b1;
                    ack_nxt  = 1'b1;
                end else if (bus.wr) begin
                    tx_nxt       = bus.dout[7:0];
                    keep_nxt     = bus.dout[8];
                    cs_n_nxt     = 1'b0;
                    sclk_nxt     = cpol;
                    mosi_nxt     = lsb ? bus.dout[0] : bus.dout[7];
                    cnt_nxt      = '0;
                    bit_cnt_nxt  = '0;
                    edge_cnt_nxt = '0;
                    state_nxt    = SETUP;
                end
            end
            SETUP: begin
                if (half_done) begin
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end else begin
                    cnt_nxt = cnt + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (half_done) begin
                    cnt_nxt      = '0;
                    sclk_nxt     = ~spi_sclk;
                    edge_cnt_nxt = edge_cnt + EDGE_W'(1);
                    if (sample) begin
                        rx_sh_nxt   = lsb ? {spi_miso, rx_sh[7:1]} : {rx_sh[6:0], spi_miso};
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    end else if (bit_cnt < NBITS) begin
                        mosi_nxt = lsb ? tx[bit_cnt[2:0]] : tx[~bit_cnt[2:0]];
                    end
                    if (edge_cnt == LAST_EDGE) begin
                        sclk_nxt = cpol;
                        if (keep) begin
                            rx_byte_nxt  = rx_sh_nxt;
                            rx_valid_nxt = 1'b1;
                            ack_nxt      = 1'b1;
                            state_nxt    = IDLE;
                        end else begin
                            state_nxt = HOLD;
                        end
                    end
                end else begin
                    cnt_nxt = cnt + DIV_W'(1);
                end
            end
            HOLD: begin
                if (half_done) begin
                    cnt_nxt      = '0;
                    cs_n_nxt     = 1'b1;
                    rx_byte_nxt  = rx_sh;
                    rx_valid_nxt = 1'b1;
                    ack_nxt      = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    cnt_nxt = cnt + DIV_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div      <= DEFAULT_DIV;
            cnt      <= '0;
            cpol     <= 1'b0;
            cpha     <= 1'b0;
            tx       <= '0;
            rx_sh    <= '0;
            rx_byte  <= '0;
            bit_cnt  <= '0;
            edge_cnt <= '0;
            keep     <= 1'b0;
            rx_valid <= 1'b0;
            rd_pend  <= 1'b0;
            ack      <= 1'b0;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            spi_cs_n <= 1'b1;
        end else begin
            state    <= state_nxt;
            div      <= div_nxt;
            cnt      <= cnt_nxt;
            cpol     <= cpol_nxt;
            cpha     <= cpha_nxt;
            tx       <= tx_nxt;
            rx_sh    <= rx_sh_nxt;
            rx_byte  <= rx_byte_nxt;
            bit_cnt  <= bit_cnt_nxt;
            edge_cnt <= edge_cnt_nxt;
            keep     <= keep_nxt;
            rx_valid <= rx_valid_nxt;
            rd_pend  <= bus.rd;
            ack      <= ack_nxt;
            spi_sclk <= sclk_nxt;
            spi_mosi <= mosi_nxt;
            spi_cs_n <= cs_n_nxt;
        end
    end
endmodule

// File: tb/tb_spi_master_core.sv
// Randomized bench for spi_master_core: a behavioural SPI slave and transaction model check timing and data.
`timescale 1ns/1ps
module tb_spi_master_core;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic spi_sclk, spi_mosi, spi_miso, spi_cs_n;

    spi_master_core_if bus();

    spi_master_core #(.DIV_W(8), .DEFAULT_DIV(8'd4)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction-level model of the configuration and receive register
    int         m_h;
    bit         m_cpol, m_cpha, m_lsb;
    bit         exp_valid;
    logic [7:0] exp_byte;

    // Behavioural slave / wire monitor
    logic [7:0] slv_byte  = 8'h00;
    bit         loopback  = 1'b0;
    int         samp_base = 0;
    int         tog_base  = 0;
    int         tog_cnt   = 0;
    int         samp_cnt  = 0;
    int         cs_rise   = 0;
    int         bad_width = 0;
    int         last_tog  = 0;
    logic [7:0] mosi_sr   = 8'h00;
    logic       prev_sclk = 1'b0;
    logic       prev_cs   = 1'b1;

    always @(negedge clk) begin
        if (!rst && spi_cs_n == 1'b0 && spi_sclk != prev_sclk) begin
            if (tog_cnt != tog_base && (cyc - last_tog) != m_h) bad_width++;
            if ((prev_sclk == m_cpol) ^ m_cpha) begin
                samp_cnt++;
                mosi_sr = {mosi_sr[6:0], spi_mosi};
            end
            tog_cnt++;
            last_tog = cyc;
        end
        if (spi_cs_n && !prev_cs) cs_rise++;
        prev_sclk = spi_sclk;
        prev_cs   = spi_cs_n;
    end

    int sidx;
    always_comb begin
        sidx = samp_cnt - samp_base;
        if (loopback)                 spi_miso = spi_mosi;
        else if (sidx >= 0 && sidx < 8) spi_miso = m_lsb ? slv_byte[sidx] : slv_byte[7-sidx];
        else                          spi_miso = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic model_reset;
        m_h = 5; m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0;
        exp_valid = 1'b0; exp_byte = 8'h00;
    endtask

    task automatic do_cmd(input logic [10:0] d);
        bus.dout = d; bus.cmd = 1'b1;
        tick;
        bus.cmd = 1'b0;
        m_cpol = d[8]; m_cpha = d[9]; m_h = int'(d[7:0]) + 1;
`ifdef SPI_LSB_FIRST_EN
        m_lsb = d[10];
`else
        m_lsb = 1'b0;
`endif
        check("cmd_ack", 32'(bus.ack), 32'd1);
        check("cmd_sclk", 32'(spi_sclk), 32'(m_cpol));
        check("cmd_cs_n", 32'(spi_cs_n), 32'd1);
        tick;
        check("cmd_ack_pulse", 32'(bus.ack), 32'd0);
    endtask

    task automatic do_rd;
        bus.rd = 1'b1;
        tick;
        bus.rd = 1'b0;
        check("rd_ack", 32'(bus.ack), 32'd1);
        check("rd_din", 32'(bus.din), 32'({exp_valid, exp_byte}));
        tick;
        check("rd_clear", 32'(bus.din), 32'({1'b0, exp_byte}));
        exp_valid = 1'b0;
    endtask

    task automatic transfer(input logic [7:0] tx, input bit keep, input logic [7:0] sbyte,
                            input bit loop, input int busy_at);
        int lat, bw0, cs0;
        slv_byte = sbyte; loopback = loop;
        samp_base = samp_cnt; tog_base = tog_cnt; bw0 = bad_width; cs0 = cs_rise;
        bus.dout = {2'b00, keep, tx}; bus.wr = 1'b1;
        lat = 0;
        for (int n = 1; n <= 3000; n++) begin
            tick;
            if (n == 1) bus.wr = 1'b0;
            if (busy_at != 0 && n == busy_at) begin
                bus.dout = 11'h7FF; bus.cmd = 1'b1;
            end
            if (busy_at != 0 && n == busy_at + 1) begin
                bus.cmd = 1'b0; bus.wr = 1'b1;
                check("busy_cmd_ack", 32'(bus.ack), 32'd0);
            end
            if (busy_at != 0 && n == busy_at + 2) begin
                bus.wr = 1'b0;
                check("busy_wr_ack", 32'(bus.ack), 32'd0);
            end
            if (bus.ack) begin
                lat = n;
                break;
            end
        end
        check("xfer_done", 32'(lat != 0), 32'd1);
        check("xfer_lat", 32'(lat), 32'(keep ? 17*m_h + 1 : 18*m_h + 1));
        check("xfer_sclk_idle", 32'(spi_sclk), 32'(m_cpol));
        check("xfer_cs_n", 32'(spi_cs_n), 32'(!keep));
        exp_valid = 1'b1;
        exp_byte  = loop ? tx : sbyte;
        tick;
        check("xfer_ack_pulse", 32'(bus.ack), 32'd0);
        check("xfer_edges", 32'(tog_cnt - tog_base), 32'd16);
        check("xfer_width", 32'(bad_width - bw0), 32'd0);
        check("xfer_mosi", 32'(mosi_sr), 32'(m_lsb ? rev8(tx) : tx));
        check("xfer_cs_rise", 32'(cs_rise - cs0), 32'(keep ? 0 : 1));
        bus.dout = 11'h000;
    endtask

    initial begin
        int acks;
        bus.dout = 11'h000; bus.cmd = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0;
        model_reset;

        // Reset state
        #2 rst = 1'b1;
        repeat (3) tick;
        check("rst_din", 32'(bus.din), 32'h000);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_sclk", 32'(spi_sclk), 32'd0);
        check("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        rst = 1'b0;
        tick;

        // Default divider from reset
        transfer(8'($urandom), 1'b0, 8'($urandom), 1'b0, 0);
        do_rd;

        // Mode 0, div=1, loopback
        do_cmd(11'h001);
        transfer(8'hA5, 1'b0, 8'h00, 1'b1, 0);
        do_rd;

        // Mode 3, div=0, miso high
        do_cmd(11'h300);
        transfer(8'h3C, 1'b0, 8'hFF, 1'b0, 0);
        do_rd;

        // Multi-byte with chip-select held, then cmd releases it
        do_cmd(11'h002);
        transfer(8'h55, 1'b1, 8'($urandom), 1'b0, 0);
        transfer(8'hAA, 1'b0, 8'($urandom), 1'b0, 0);
        transfer(8'h96, 1'b1, 8'($urandom), 1'b0, 0);
        do_cmd(11'h001);

        // Overwrite of unread data, then busy cmd/wr ignored
        transfer(8'h11, 1'b0, 8'h00, 1'b1, 0);
        transfer(8'h22, 1'b0, 8'h00, 1'b1, 0);
        do_rd;
        transfer(8'h5A, 1'b0, 8'($urandom), 1'b0, m_h + 4);
        transfer(8'hC3, 1'b0, 8'($urandom), 1'b0, 0);
        do_rd;

        // Bit order select
        do_cmd(11'h400);
        transfer(8'h01, 1'b0, 8'h00, 1'b1, 0);
`ifdef SPI_LSB_FIRST_EN
        check("lsb_order", 32'(mosi_sr), 32'h80);
`else
        check("lsb_order", 32'(mosi_sr), 32'h01);
`endif
        do_rd;

        // Reset mid-SHIFT with SCLK idling high
        do_cmd(11'h102);
        bus.dout = 11'h0C3; bus.wr = 1'b1;
        tick;
        bus.wr = 1'b0;
        repeat (m_h * 4) tick;
        rst = 1'b1;
        #2;
        check("rst_mid_cs_n", 32'(spi_cs_n), 32'd1);
        check("rst_mid_sclk", 32'(spi_sclk), 32'd0);
        check("rst_mid_ack", 32'(bus.ack), 32'd0);
        check("rst_mid_din", 32'(bus.din), 32'h000);
        tick; tick;
        rst = 1'b0;
        model_reset;
        acks = 0;
        repeat (100) begin
            tick;
            if (bus.ack) acks++;
        end
        check("rst_no_ack", 32'(acks), 32'd0);
        transfer(8'($urandom), 1'b0, 8'($urandom), 1'b0, 0);

        // Randomized configurations and transfers
        for (int i = 0; i < 24; i++) begin
            do_cmd({3'($urandom), 8'($urandom_range(0, 3))});
            transfer(8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 0);
            if ($urandom_range(0, 1) == 1) do_rd;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
